multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/risc_pkg.sv | 54 +++++
 rtl/mc_ack_timer.sv | 29 ++
 rtl/multicycle_ctrl.sv | 133 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared encodings for the multicycle controller: state codes, datapath
// select codes and the opcode map, plus the DECODE dispatch function.
package risc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_WB_R     = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_WB_LD    = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALTED   = 4'd11,
        ST_ERROR    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_TWO  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [3:0] OP_LD       = 4'b0000;
    localparam logic [3:0] OP_ST       = 4'b0001;
    localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
    localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
    localparam logic [3:0] OP_BEQ      = 4'b1011;
    localparam logic [3:0] OP_BNE      = 4'b1100;
    localparam logic [3:0] OP_JMP      = 4'b1101;
    localparam logic [3:0] OP_HALT     = 4'b1111;

    // Reserved opcodes (1010, 1110) fall through to ERROR.
    function automatic state_t decode_next(input logic [3:0] op);
        case (op)
            OP_LD, OP_ST:   decode_next = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: decode_next = ST_BRANCH;
            OP_JMP:         decode_next = ST_JUMP;
            OP_HALT:        decode_next = ST_HALTED;
            default:        decode_next = (op >= OP_RTYPE_LO && op <= OP_RTYPE_HI)
                                          ? ST_EXEC_R : ST_ERROR;
        endcase
    endfunction

endpackage

// File: rtl/mc_ack_timer.sv
// Memory-acknowledge wait counter; expired flags the last cycle a pending
// request may still be acknowledged before the controller gives up.
module mc_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC control unit: registered state, outputs decoded from the
// current state (ir_write/pc_write in FETCH and pc_write in BRANCH are gated).
module multicycle_ctrl
    import risc_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       err,
    output logic [3:0] state
);

    state_t cur;
    logic   in_wait;
    logic   expired;

    // The counter is held at zero outside the wait states, so it always
    // starts from zero on entry; an ack also zeroes it as the state is left.
    assign in_wait = (cur == ST_FETCH) || (cur == ST_MEM_RD) || (cur == ST_MEM_WR);

    mc_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (~in_wait | mem_ack),
        .count_en (in_wait & ~mem_ack),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= ST_IDLE;
        end else begin
            case (cur)
                ST_IDLE:     cur <= ST_FETCH;
                ST_FETCH:    if (mem_ack) cur <= ST_DECODE;
                             else if (expired) cur <= ST_ERROR;
                ST_DECODE:   cur <= decode_next(opcode);
                ST_EXEC_R:   cur <= ST_WB_R;
                ST_WB_R:     cur <= ST_FETCH;
                ST_MEM_ADDR: cur <= (opcode == OP_ST) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD:   if (mem_ack) cur <= ST_WB_LD;
                             else if (expired) cur <= ST_ERROR;
                ST_WB_LD:    cur <= ST_FETCH;
                ST_MEM_WR:   if (mem_ack) cur <= ST_FETCH;
                             else if (expired) cur <= ST_ERROR;
                ST_BRANCH:   cur <= ST_FETCH;
                ST_JUMP:     cur <= ST_FETCH;
                ST_HALTED:   cur <= ST_HALTED;
                ST_ERROR:    cur <= ST_ERROR;
                default:     cur <= ST_ERROR;
            endcase
        end
    end

    always_comb begin
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        err        = 1'b0;
        case (cur)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_TWO;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            ST_DECODE:   alu_src_b = SRCB_IMM;
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            ST_WB_R:     reg_write = 1'b1;
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            ST_HALTED:   halted = 1'b1;
            ST_ERROR:    err = 1'b1;
            default:     ;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the
// hand-derived expected state/output vector, a negedge monitor compares it.
module tb_multicycle_ctrl;
    import risc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic [1:0] alu_op, alu_src_b, pc_src;
    logic       alu_src_a, pc_write, ir_write, mem_req, mem_we, iord;
    logic       reg_write, mem_to_reg, halted, err;
    logic [3:0] state;

    multicycle_ctrl #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] vec;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Hand-written output table, bit order:
    // alu_op(2) src_a src_b(2) pc_write pc_src(2) ir_write mem_req mem_we iord
    // reg_write mem_to_reg halted err
    function automatic logic [15:0] base(input state_t s);
        case (s)
            ST_FETCH:    return 16'b00_0_01_0_00_0_1_0_0_0_0_0_0;
            ST_DECODE:   return 16'b00_0_10_0_00_0_0_0_0_0_0_0_0;
            ST_EXEC_R:   return 16'b10_1_00_0_00_0_0_0_0_0_0_0_0;
            ST_WB_R:     return 16'b00_0_00_0_00_0_0_0_0_1_0_0_0;
            ST_MEM_ADDR: return 16'b00_1_10_0_00_0_0_0_0_0_0_0_0;
            ST_MEM_RD:   return 16'b00_0_00_0_00_0_1_0_1_0_0_0_0;
            ST_WB_LD:    return 16'b00_0_00_0_00_0_0_0_0_1_1_0_0;
            ST_MEM_WR:   return 16'b00_0_00_0_00_0_1_1_1_0_0_0_0;
            ST_BRANCH:   return 16'b01_1_00_0_01_0_0_0_0_0_0_0_0;
            ST_JUMP:     return 16'b00_0_00_1_10_0_0_0_0_0_0_0_0;
            ST_HALTED:   return 16'b00_0_00_0_00_0_0_0_0_0_0_1_0;
            ST_ERROR:    return 16'b00_0_00_0_00_0_0_0_0_0_0_0_1;
            default:     return 16'b0;
        endcase
    endfunction

    task automatic step(input logic [3:0] op, input logic z, input logic ack,
                        input state_t st, input logic pw, input logic ir,
                        input string name);
        exp_t e;
        opcode  = op;
        zero    = z;
        mem_ack = ack;
        e.vec   = {4'(st), base(st) | (16'(pw) << 10) | (16'(ir) << 7)};
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [19:0] act;
        cyc <= cyc + 1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {state, alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                   mem_req, mem_we, iord, reg_write, mem_to_reg, halted, err};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %b required %b", e.name, cyc, act, e.vec);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset state, then release: first edge goes IDLE -> FETCH.
        rst = 1'b1;
        step(4'b0010, 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0, "reset_idle");
        rst = 1'b0;
        step(4'b0010, 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0, "post_reset_idle");
        // ADD with immediate ack.
        step(4'b0010, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "add_fetch");
        step(4'b0010, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "add_decode");
        step(4'b0010, 1'b0, 1'b0, ST_EXEC_R, 1'b0, 1'b0, "add_exec");
        step(4'b0010, 1'b0, 1'b0, ST_WB_R,   1'b0, 1'b0, "add_wb");
        // LD with ack delayed 3 cycles in MEM_RD.
        step(4'b0000, 1'b0, 1'b1, ST_FETCH,    1'b1, 1'b1, "ld_fetch");
        step(4'b0000, 1'b0, 1'b0, ST_DECODE,   1'b0, 1'b0, "ld_decode");
        step(4'b0000, 1'b0, 1'b0, ST_MEM_ADDR, 1'b0, 1'b0, "ld_addr");
        step(4'b0000, 1'b0, 1'b0, ST_MEM_RD,   1'b0, 1'b0, "ld_rd_wait1");
        step(4'b0000, 1'b0, 1'b0, ST_MEM_RD,   1'b0, 1'b0, "ld_rd_wait2");
        step(4'b0000, 1'b0, 1'b0, ST_MEM_RD,   1'b0, 1'b0, "ld_rd_wait3");
        step(4'b0000, 1'b0, 1'b1, ST_MEM_RD,   1'b0, 1'b0, "ld_rd_ack");
        step(4'b0000, 1'b0, 1'b0, ST_WB_LD,    1'b0, 1'b0, "ld_wb");
        // ST with immediate ack.
        step(4'b0001, 1'b0, 1'b1, ST_FETCH,    1'b1, 1'b1, "st_fetch");
        step(4'b0001, 1'b0, 1'b0, ST_DECODE,   1'b0, 1'b0, "st_decode");
        step(4'b0001, 1'b0, 1'b0, ST_MEM_ADDR, 1'b0, 1'b0, "st_addr");
        step(4'b0001, 1'b0, 1'b1, ST_MEM_WR,   1'b0, 1'b0, "st_wr_ack");
        // Branches, all four zero/opcode combinations.
        step(4'b1011, 1'b1, 1'b1, ST_FETCH,  1'b1, 1'b1, "beq_fetch");
        step(4'b1011, 1'b1, 1'b0, ST_DECODE, 1'b0, 1'b0, "beq_decode");
        step(4'b1011, 1'b1, 1'b0, ST_BRANCH, 1'b1, 1'b0, "beq_z1_taken");
        step(4'b1100, 1'b1, 1'b1, ST_FETCH,  1'b1, 1'b1, "bne_fetch");
        step(4'b1100, 1'b1, 1'b0, ST_DECODE, 1'b0, 1'b0, "bne_decode");
        step(4'b1100, 1'b1, 1'b0, ST_BRANCH, 1'b0, 1'b0, "bne_z1_not_taken");
        step(4'b1011, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "beq0_fetch");
        step(4'b1011, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "beq0_decode");
        step(4'b1011, 1'b0, 1'b0, ST_BRANCH, 1'b0, 1'b0, "beq_z0_not_taken");
        step(4'b1100, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "bne0_fetch");
        step(4'b1100, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "bne0_decode");
        step(4'b1100, 1'b0, 1'b0, ST_BRANCH, 1'b1, 1'b0, "bne_z0_taken");
        // Ack on the 16th FETCH cycle wins over the timeout.
        for (int i = 0; i < 15; i++)
            step(4'b1101, 1'b0, 1'b0, ST_FETCH, 1'b0, 1'b0, "fetch_wait");
        step(4'b1101, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "fetch_ack_at_limit");
        step(4'b1101, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "jmp_decode");
        step(4'b1101, 1'b0, 1'b0, ST_JUMP,   1'b0, 1'b0, "jmp_jump");
        // ST interrupted by an async reset mid-MEM_WR; a later ack is ignored.
        step(4'b0001, 1'b0, 1'b1, ST_FETCH,    1'b1, 1'b1, "st2_fetch");
        step(4'b0001, 1'b0, 1'b0, ST_DECODE,   1'b0, 1'b0, "st2_decode");
        step(4'b0001, 1'b0, 1'b0, ST_MEM_ADDR, 1'b0, 1'b0, "st2_addr");
        step(4'b0001, 1'b0, 1'b0, ST_MEM_WR,   1'b0, 1'b0, "st2_wr_wait");
        rst = 1'b1;
        step(4'b0001, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0, "rst_mid_wr");
        rst = 1'b0;
        step(4'b0001, 1'b0, 1'b1, ST_IDLE, 1'b0, 1'b0, "late_ack_ignored");
        // No ack at all: ERROR after 16 FETCH cycles, sticky.
        for (int i = 0; i < 16; i++)
            step(4'b0010, 1'b0, 1'b0, ST_FETCH, 1'b0, 1'b0, "fetch_no_ack");
        step(4'b0010, 1'b0, 1'b0, ST_ERROR, 1'b0, 1'b0, "timeout_error");
        step(4'b0010, 1'b0, 1'b1, ST_ERROR, 1'b0, 1'b0, "error_sticky");
        step(4'b0010, 1'b0, 1'b0, ST_ERROR, 1'b0, 1'b0, "error_sticky2");
        // HALT opcode.
        rst = 1'b1;
        step(4'b1111, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0, "rst_from_error");
        rst = 1'b0;
        step(4'b1111, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, "halt_idle");
        step(4'b1111, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "halt_fetch");
        step(4'b1111, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "halt_decode");
        step(4'b1111, 1'b0, 1'b1, ST_HALTED, 1'b0, 1'b0, "halted");
        step(4'b0010, 1'b0, 1'b1, ST_HALTED, 1'b0, 1'b0, "halted_held");
        // Reserved opcode 1010 decodes to ERROR.
        rst = 1'b1;
        step(4'b1010, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0, "rst_from_halt");
        rst = 1'b0;
        step(4'b1010, 1'b0, 1'b0, ST_IDLE,   1'b0, 1'b0, "bad_idle");
        step(4'b1010, 1'b0, 1'b1, ST_FETCH,  1'b1, 1'b1, "bad_fetch");
        step(4'b1010, 1'b0, 1'b0, ST_DECODE, 1'b0, 1'b0, "bad_decode");
        step(4'b1010, 1'b0, 1'b0, ST_ERROR,  1'b0, 1'b0, "bad_opcode_error");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
